// File: rtl/mmio_peripheral_responder.sv
// MMIO peripheral on the data-memory bus: PWM duty registers for LED/RGB,
// free-running microsecond/millisecond timers and a control register.
// Loads are registered (1-cycle latency); stores update byte lanes at posedge.
module mmio_peripheral_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
  parameter int          CLK_FREQ_HZ = 12000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  funct3,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  output logic [31:0] dmem_data_out,
  output logic        hit,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int US_DIV = CLK_FREQ_HZ / 1000000;
  localparam int PW     = (US_DIV > 2) ? $clog2(US_DIV) : 1;
  localparam logic [PW-1:0] US_LAST = PW'(US_DIV - 1);

  logic [31:0]   r_duty, r_sh_duty, r_micros, r_millis, r_rdata;
  logic          r_ctrl, r_hit;
  logic [PW-1:0] r_us_pre;
  logic [9:0]    r_ms_pre;
  logic [7:0]    r_pwm_cnt;
  logic [3:0]    r_pwm;   // {blue, green, red, led}

  logic          w_in_win, w_aligned, w_we, w_us_tick;
  logic [1:0]    w_lane, w_sel;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_reg, w_shift, w_load;

  // Address decode, alignment, byte-lane enables and load data formatting
  always_comb begin
    w_in_win  = (dmem_address[31:4] == BASE_ADDR[31:4]);
    w_lane    = dmem_address[1:0];
    w_sel     = dmem_address[3:2];
    w_aligned = 1'b0;
    w_be      = 4'b0000;
    w_wdata   = dmem_data_in;
    case (funct3)
      3'b000, 3'b100: begin
        w_aligned = 1'b1;
        w_be      = 4'b0001 << w_lane;
        w_wdata   = {4{dmem_data_in[7:0]}};
      end
      3'b001, 3'b101: begin
        w_aligned = ~w_lane[0];
        w_be      = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{dmem_data_in[15:0]}};
      end
      3'b010: begin
        w_aligned = (w_lane == 2'b00);
        w_be      = 4'b1111;
      end
      default: w_aligned = 1'b0;
    endcase
    w_we = dmem_wren & w_in_win & w_aligned;

    case (w_sel)
      2'd0:    w_reg = r_duty;
      2'd1:    w_reg = r_micros;
      2'd2:    w_reg = r_millis;
      default: w_reg = {31'b0, r_ctrl};
    endcase
    w_shift = w_reg >> {w_lane, 3'b000};
    case (funct3)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b010:  w_load = w_reg;
      3'b100:  w_load = {24'b0, w_shift[7:0]};
      3'b101:  w_load = {16'b0, w_shift[15:0]};
      default: w_load = 32'b0;
    endcase
    if (!(w_in_win && w_aligned)) w_load = 32'b0;

    w_us_tick = (r_us_pre == US_LAST);
  end

  // Register writes and registered load response; reset wins over a store
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_duty  <= '0;
      r_ctrl  <= 1'b0;
      r_rdata <= '0;
      r_hit   <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (w_we && w_sel == 2'd0 && w_be[b])
          r_duty[b*8 +: 8] <= w_wdata[b*8 +: 8];
      if (w_we && w_sel == 2'd3 && w_be[0])
        r_ctrl <= w_wdata[0];
      r_rdata <= w_load;
      r_hit   <= w_in_win;
    end
  end

  // Microsecond prescaler feeding MICROS and the millisecond prescaler
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_us_pre <= '0;
      r_ms_pre <= '0;
      r_micros <= '0;
      r_millis <= '0;
    end else begin
      r_us_pre <= w_us_tick ? '0 : r_us_pre + PW'(1);
      if (w_us_tick) begin
        r_micros <= r_micros + 32'd1;
        if (r_ms_pre == 10'd999) begin
          r_ms_pre <= '0;
          r_millis <= r_millis + 32'd1;
        end else begin
          r_ms_pre <= r_ms_pre + 10'd1;
        end
      end
    end
  end

  // PWM: free-running counter, shadow duty reload at period end, registered compare
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pwm_cnt <= '0;
      r_sh_duty <= '0;
      r_pwm     <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      if (r_pwm_cnt == 8'hFF) r_sh_duty <= r_duty;
      for (int c = 0; c < 4; c++)
        r_pwm[c] <= r_ctrl & (r_pwm_cnt < r_sh_duty[c*8 +: 8]);
    end
  end

  assign dmem_data_out = r_rdata;
  assign hit           = r_hit;
  assign led           = r_pwm[0];
  assign red           = r_pwm[1];
  assign green         = r_pwm[2];
  assign blue          = r_pwm[3];

endmodule

// File: doc/mmio_peripheral_responder.md
Name: mmio_peripheral_responder

Overview:
- Memory-mapped peripheral slave on the processor's data-memory bus. It answers the core's load/store requests (funct3-sized, byte-addressed) within a small register window.
- Registers: PWM duty for the LED and the RGB channels, free-running microsecond/millisecond timers, and a control register.
- Sits beside the main memory on the dmem bus. The top-level selects this block's read data when `hit` is high.
- Drives active-high `led`, `red`, `green` and `blue`. The top level inverts them for the pins.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00, base of the 16-byte register window; must be 16-byte aligned.
- CLK_FREQ_HZ, 12000000, system clock frequency; CLK_FREQ_HZ/1000000 must be an integer ≥ 2.

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  synchronous reset, active-low (asserted when 0)
- funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- dmem_wren  input  1  store strobe, sampled on posedge
- dmem_address  input  32  byte address
- dmem_data_in  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- dmem_data_out  output  32  load data, right-aligned and extended per funct3
- hit  output  1  registered: previous-cycle address was inside the window
- led, red, green, blue  output  1 each  PWM outputs, active-high

Behaviour:
- Register map (offset = address - BASE_ADDR):
  - 0x0: DUTY, RW. [7:0] led, [15:8] red, [23:16] green, [31:24] blue.
  - 0x4: MICROS, RO.
  - 0x8: MILLIS, RO.
  - 0xC: CTRL, RW. bit0 pwm_en; bits [31:1] read 0.
- Reset (reset==0 at posedge):
  - DUTY=0, CTRL=0, MICROS=0, MILLIS=0, all prescalers=0, pwm counter=0, shadow duties=0.
  - dmem_data_out=0, hit=0, all PWM outputs 0.
  - Reset mid-operation overrides any store in the same cycle.
- In-window: address[31:4]==BASE_ADDR[31:4].
- Alignment:
  - Half accesses need address[0]==0.
  - Word accesses need address[1:0]==00.
  - Misaligned or out-of-window stores have no effect. Misaligned loads return 0. funct3 values 011/110/111 are treated as misaligned.
- Store (dmem_wren==1, in-window, aligned):
  - Byte lanes updated at the posedge: byte → lane address[1:0]; half → lanes address[1]*2+{0,1}; word → all lanes.
  - Stores to MICROS/MILLIS are ignored.
- Load:
  - dmem_data_out and hit are registered, with exactly 1-cycle latency: the value reflects the address and funct3 sampled at posedge N and is visible after posedge N.
  - Data is the selected lane(s) shifted to bit 0. funct3 000/001 sign-extend; 100/101 zero-extend; 010 passes the full word.
  - Out-of-window: data=0, hit=0.
  - A load and store to the same register in the same cycle returns the OLD value.
  - A timer read returns the value before that edge's increment.
- Timers:
  - The us prescaler counts 0..CLK_FREQ_HZ/1000000-1.
  - On its terminal count it returns to 0 and MICROS increments.
  - A ms prescaler counts those µs ticks 0..999; on each 1000th tick MILLIS increments.
  - Both counters wrap 0xFFFF_FFFF → 0 silently.
- PWM:
  - An 8-bit counter increments every clk, wrapping 255→0.
  - Shadow duties are loaded from DUTY when the counter==255, so duty changes take effect at a period boundary and are glitch-free.
  - Output = pwm_en & (counter < shadow_duty), registered.
  - Duty 0 → constantly 0; duty 255 → high 255 of every 256 cycles.
  - pwm_en=0 forces all outputs 0 within 1 cycle; the counter keeps running.

Test Plan:
- Reset then read: hold reset=0 for 2 cycles, release; lw at 0xFFFF_FF00 → dmem_data_out=0, hit=1 one cycle later; led/red/green/blue=0.
- Sized store/load: sw 0x80FF_7F01 to 0x00; lb at 0x03 → 0xFFFF_FF80; lbu at 0x03 → 0x0000_0080; lh at 0x02 → 0xFFFF_80FF; lhu at 0x00 → 0x0000_7F01.
- Illegal accesses:
  - sh to 0x01 leaves DUTY unchanged; lw at 0x02 → 0.
  - sw 0x1234 to 0x04 leaves MICROS counting from its prior value.
  - lw at 0xFFFF_FE00 → data 0, hit 0.
- Timers (CLK_FREQ_HZ=12e6): after release run 12000 cycles; MICROS=1000 and MILLIS=1. Force MICROS to 0xFFFF_FFFF; the next µs tick gives 0.
- PWM: sw CTRL=1, DUTY=0x00FF_4000.
  - After the next counter==255 edge, over 256 cycles: led high 0 cycles, red 64, green 255, blue 0.
  - Changing DUTY mid-period alters the outputs only from the next period.
- Reset mid-store: sw DUTY=0xFFFF_FFFF in the same cycle reset=0 → DUTY reads 0 after release.
